// File: rtl/divx_pkg.sv
// Shared constants and helpers for the divx_multi clock/tick divider.
package divx_pkg;

  localparam int DEF_DIV  = 25000;
  localparam int DEF_HIGH = 12500;

  function automatic int ch_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  function automatic logic [31:0] clamp_div(
    input logic [31:0] d
  );
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

  // d is expected to be already clamped (>= 2)
  function automatic logic [31:0] clamp_high(
    input logic [31:0] h,
    input logic [31:0] d
  );
    return (h > d - 32'd1) ? d - 32'd1 : h;
  endfunction

endpackage

// File: rtl/divx_chan.sv
// One divider channel: counter, active/shadow config, CLKout and tick.
// DIVX_SYNC_EN adds a sync input that restarts the period.
module divx_chan
  import divx_pkg::*;
#(
  parameter int W        = 16,
  parameter int DEF_DIV  = divx_pkg::DEF_DIV,
  parameter int DEF_HIGH = divx_pkg::DEF_HIGH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
`ifdef DIVX_SYNC_EN
  input  logic         sync,
`endif
  input  logic         acc,
  input  logic [W-1:0] div,
  input  logic [W-1:0] high,
  output logic         pending,
  output logic         clk_out,
  output logic         tick
);

  logic [W-1:0] cnt;
  logic [W-1:0] div_a;
  logic [W-1:0] high_a;
  logic [W-1:0] sh_div;
  logic [W-1:0] sh_high;
  logic [W-1:0] new_div;
  logic [W-1:0] new_high;
  logic [W-1:0] cnt_next;
  logic [W-1:0] high_n;
  logic         wrap;
  logic         restart;
  logic         bound;
  logic         load;

  always_comb begin
    new_div  = W'(clamp_div(32'(div)));
    new_high = W'(clamp_high(32'(high),
                             32'(new_div)));
`ifdef DIVX_SYNC_EN
    restart  = sync;
`else
    restart  = 1'b0;
`endif
    wrap     = (cnt == div_a - 1'b1);
    bound    = restart | wrap;
    // disabled channels take shadow config at once
    load     = pending & (~en | bound);
    cnt_next = bound ? '0 : cnt + 1'b1;
    high_n   = load ? sh_high : high_a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      div_a   <= W'(DEF_DIV);
      high_a  <= W'(DEF_HIGH);
      sh_div  <= '0;
      sh_high <= '0;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (load) begin
        div_a   <= sh_div;
        high_a  <= sh_high;
        pending <= 1'b0;
      end else if (acc) begin
        sh_div  <= new_div;
        sh_high <= new_high;
        pending <= 1'b1;
      end
      if (!en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else begin
        cnt     <= cnt_next;
        clk_out <= (cnt_next < high_n);
        tick    <= bound;
      end
    end
  end

endmodule

// File: rtl/divx_multi.sv
// N-channel programmable clock/tick divider with valid/ready config port.
// DIVX_SYNC_EN adds a global sync input.
module divx_multi
  import divx_pkg::*;
#(
  parameter int CH       = 4,
  parameter int W        = 16,
  parameter int DEF_DIV  = divx_pkg::DEF_DIV,
  parameter int DEF_HIGH = divx_pkg::DEF_HIGH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CH-1:0]         en,
`ifdef DIVX_SYNC_EN
  input  logic                  sync,
`endif
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ch_w(CH)-1:0]   cfg_ch,
  input  logic [W-1:0]          cfg_div,
  input  logic [W-1:0]          cfg_high,
  output logic [CH-1:0]         pending,
  output logic [CH-1:0]         CLKout,
  output logic [CH-1:0]         tick
);

  logic          hit;
  logic [CH-1:0] acc;

  always_comb begin
    hit       = (32'(cfg_ch) < 32'(CH));
    cfg_ready = hit && !pending[cfg_ch];
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign acc[i] = cfg_valid & cfg_ready
                  & (32'(cfg_ch) == i);

    divx_chan #(
      .W        (W),
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_chan (
      .clk     (CLK),
      .rst     (RST),
      .en      (en[i]),
`ifdef DIVX_SYNC_EN
      .sync    (sync),
`endif
      .acc     (acc[i]),
      .div     (cfg_div),
      .high    (cfg_high),
      .pending (pending[i]),
      .clk_out (CLKout[i]),
      .tick    (tick[i])
    );
  end

endmodule
